// File: rtl/student_fir_pkg.sv
// Shared definitions for the FIR result sink: default widths and the
// round-half-up / saturate helper used by the result pipeline.
package student_fir_pkg;

  localparam int DEF_DATA_SIZE_FIR_OUT = 32;
  localparam int DEF_DATA_SIZE         = 16;
  localparam int DEF_FRAC_SHIFT        = 15;
  localparam int DEF_DEPTH_LOG2        = 4;
  localparam int DEF_CNT_WIDTH         = 16;

  // Working width of the rounding arithmetic. Any accumulator up to 63 bits
  // gets at least one guard bit, so the rounding add can never wrap.
  localparam int RS_WORK_W = 64;

  typedef struct packed {
    logic [RS_WORK_W-1:0] value;  // clamped result, sign-extended to RS_WORK_W
    logic                 sat;    // result was clamped to the output range
  } round_sat_t;

  // Round half toward +inf, arithmetic shift right by frac_shift, then clamp
  // to a signed out_w-bit range. The input must already be sign-extended.
  function automatic round_sat_t round_sat(
    input logic signed [RS_WORK_W-1:0] y,
    input int unsigned                 out_w,
    input int unsigned                 frac_shift
  );
    logic signed [RS_WORK_W-1:0] half;
    logic signed [RS_WORK_W-1:0] r;
    logic signed [RS_WORK_W-1:0] max_v;
    logic signed [RS_WORK_W-1:0] min_v;
    round_sat_t                  res;
    half  = RS_WORK_W'(1) << (frac_shift - 1);
    r     = (y + half) >>> frac_shift;
    max_v = (RS_WORK_W'(1) << (out_w - 1)) - RS_WORK_W'(1);
    min_v = -(RS_WORK_W'(1) << (out_w - 1));
    if (r > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (r < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end else begin
      res.value = r;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/student_fir_result_sink_if.sv
// FIR-side strobe/data and consumer-side valid/ready stream of the result sink.
interface student_fir_result_sink_if
  import student_fir_pkg::*;
#(
  parameter int DATA_SIZE_FIR_OUT = DEF_DATA_SIZE_FIR_OUT,
  parameter int DATA_SIZE         = DEF_DATA_SIZE
);

  logic                         valid_strobe_in;
  logic [DATA_SIZE_FIR_OUT-1:0] y_in;
  logic [DATA_SIZE-1:0]         sample_out;
  logic                         valid_out;
  logic                         ready_in;

  // Environment side: drives the filter result and consumes samples.
  modport master (
    output valid_strobe_in,
    output y_in,
    output ready_in,
    input  sample_out,
    input  valid_out
  );

  // Sink side: the result sink itself.
  modport slave (
    input  valid_strobe_in,
    input  y_in,
    input  ready_in,
    output sample_out,
    output valid_out
  );

endinterface

// File: rtl/student_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; a push is accepted on a full FIFO only when a pop
// frees the head in the same cycle.
module student_sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; clear empties the FIFO and wins over push/pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately left without reset; the pointers alone
  // define which entries are live, and a resettable array would cost a flop
  // per bit instead of RAM.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/student_fir_result_sink.sv
// Receiving end of the FIR output: detects the strobe edge, captures the
// accumulator, rounds/scales/saturates it to sample width and queues it for a
// valid/ready consumer. Tracks saturation and dropped results.
module student_fir_result_sink
  import student_fir_pkg::*;
#(
  parameter int DATA_SIZE_FIR_OUT = DEF_DATA_SIZE_FIR_OUT,
  parameter int DATA_SIZE         = DEF_DATA_SIZE,
  parameter int FRAC_SHIFT        = DEF_FRAC_SHIFT,
  parameter int DEPTH_LOG2        = DEF_DEPTH_LOG2,
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  student_fir_result_sink_if.slave     bus,
  output logic [DEPTH_LOG2:0]          fill_level_o,
  output logic                         overflow_o,
  output logic [CNT_WIDTH-1:0]         sat_count_o,
  output logic [CNT_WIDTH-1:0]         drop_count_o
);

  // Edge detection
  logic                         strobe_prev;
  logic                         event_det;

  // Pipeline
  logic                         s1_valid;
  logic [DATA_SIZE_FIR_OUT-1:0] s1_y;
  logic [RS_WORK_W-1:0]         s1_y_ext;
  round_sat_t                   rs;
  logic                         rs_value_unused;
  logic                         s2_valid;
  logic [DATA_SIZE-1:0]         s2_sample;

  // FIFO interface
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [DATA_SIZE-1:0]         fifo_rdata;
  logic                         drop;

  assign event_det = bus.valid_strobe_in && !strobe_prev;

  // Previous strobe level; keeps updating during clear so a held strobe
  // does not re-trigger once clear is released.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) strobe_prev <= 1'b0;
    else       strobe_prev <= bus.valid_strobe_in;
  end

  // S1: capture the accumulator on the strobe's rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else begin
      s1_valid <= event_det;
      if (event_det) s1_y <= bus.y_in;
    end
  end

  // Sign-extend into the working width, then round and clamp.
  assign s1_y_ext = {{(RS_WORK_W-DATA_SIZE_FIR_OUT){s1_y[DATA_SIZE_FIR_OUT-1]}}, s1_y};
  assign rs       = round_sat(s1_y_ext, DATA_SIZE, FRAC_SHIFT);
  // Upper bits of the clamped value are sign copies and are not needed.
  assign rs_value_unused = ^rs.value[RS_WORK_W-1:DATA_SIZE];

  // S2: register the rounded/saturated sample; this stage feeds the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid  <= 1'b0;
      s2_sample <= '0;
    end else if (clear_i) begin
      s2_valid  <= 1'b0;
      s2_sample <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_sample <= rs.value[DATA_SIZE-1:0];
    end
  end

  // A full FIFO still accepts a result when its head leaves in the same cycle.
  assign fifo_pop  = !fifo_empty && bus.ready_in;
  assign fifo_push = s2_valid && (!fifo_full || fifo_pop);
  assign drop      = s2_valid && fifo_full && !fifo_pop;

  student_sync_fifo #(
    .WIDTH      (DATA_SIZE),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push    (fifo_push),
    .wdata   (s2_sample),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level_o)
  );

  // Head sample is forced to zero while empty so reset shows a clean output.
  assign bus.valid_out  = !fifo_empty;
  assign bus.sample_out = fifo_empty ? '0 : fifo_rdata;

  // Saturation counter, counted when the clamped sample is registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_count_o <= '0;
    end else if (clear_i) begin
      sat_count_o <= '0;
    end else if (s1_valid && rs.sat && (sat_count_o != '1)) begin
      sat_count_o <= sat_count_o + 1'b1;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (clear_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != '1) drop_count_o <= drop_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_student_fir_result_sink.sv
// Self-checking bench for student_fir_result_sink: directed scenarios followed
// by randomized traffic, all compared every cycle against a queue-based model.
module tb_student_fir_result_sink;

  localparam int DW_IN = 32;
  localparam int DW    = 16;
  localparam int SH    = 15;
  localparam int DL    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic [DL:0]   fill_level_o;
  logic          overflow_o;
  logic [CW-1:0] sat_count_o;
  logic [CW-1:0] drop_count_o;

  student_fir_result_sink_if #(.DATA_SIZE_FIR_OUT(DW_IN), .DATA_SIZE(DW)) bus ();

  student_fir_result_sink #(
    .DATA_SIZE_FIR_OUT (DW_IN),
    .DATA_SIZE         (DW),
    .FRAC_SHIFT        (SH),
    .DEPTH_LOG2        (DL),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .bus          (bus),
    .fill_level_o (fill_level_o),
    .overflow_o   (overflow_o),
    .sat_count_o  (sat_count_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;   // clock edge at which the result reaches the FIFO
    logic [15:0] val;
    bit          sat;
  } pend_t;

  pend_t       pend[$];
  logic [15:0] mq[$];
  int          m_sat;
  int          m_drop;
  bit          m_ovf;
  bit          m_prev;
  int          edge_n;
  int          total;
  int          bad;

  // Expected sample: floor((y + 2^14) / 2^15), clamped to 16-bit signed.
  function automatic void ref_result(input logic [31:0] y, output logic [15:0] v, output bit s);
    longint num;
    longint q;
    num = longint'($signed(y)) + 64'sd16384;
    q   = num / 64'sd32768;
    if ((num % 64'sd32768) != 0 && num < 0) q = q - 1;
    if (q > 32767) begin
      v = 16'h7FFF; s = 1'b1;
    end else if (q < -32768) begin
      v = 16'h8000; s = 1'b1;
    end else begin
      v = q[15:0]; s = 1'b0;
    end
  endfunction

  function automatic int bump(input int c);
    return (c >= 65535) ? c : c + 1;
  endfunction

  task automatic model_flush();
    mq.delete();
    pend.delete();
    m_sat  = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic tick();
    logic        strobe_now;
    logic        clr_now;
    logic [31:0] y_now;
    bit          ev;
    bit          pop;
    bit          push_ok;
    logic [15:0] v;
    bit          s;
    strobe_now = bus.valid_strobe_in;
    clr_now    = clear_i;
    y_now      = bus.y_in;
    ev         = strobe_now && !m_prev;
    pop        = (mq.size() > 0) && bus.ready_in;
    @(posedge clk_i);
    edge_n++;
    m_prev = strobe_now;
    if (clr_now) begin
      model_flush();
      return;
    end
    foreach (pend[i]) if (pend[i].due - 1 == edge_n && pend[i].sat) m_sat = bump(m_sat);
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      v = pend[0].val;
      void'(pend.pop_front());
      push_ok = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (push_ok) mq.push_back(v);
      else begin
        m_ovf  = 1;
        m_drop = bump(m_drop);
      end
    end else if (pop) begin
      void'(mq.pop_front());
    end
    if (ev) begin
      ref_result(y_now, v, s);
      pend.push_back('{due: edge_n + 2, val: v, sat: s});
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("valid_out", 64'(bus.valid_out), 64'(mq.size() != 0));
    check("fill_level", 64'(fill_level_o), 64'(mq.size()));
    if (mq.size() > 0) check("sample_out", 64'(bus.sample_out), 64'(mq[0]));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("sat_count", 64'(sat_count_o), 64'(m_sat));
    check("drop_count", 64'(drop_count_o), 64'(m_drop));
  endtask

  // One clock: model and DUT advance, then compare on the falling edge.
  task automatic cyc();
    tick();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [31:0] y);
    bus.y_in            = y;
    bus.valid_strobe_in = 1'b1;
    cyc();
    bus.valid_strobe_in = 1'b0;
    cyc();
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
  endtask

  task automatic queue_five_and_launch();
    bus.ready_in = 1'b0;
    send(32'h4000_0000);
    for (int k = 1; k <= 4; k++) send(32'(k) << 15);
    idle(3);
    check("pre_flush_level", 64'(fill_level_o), 64'd5);
    bus.y_in            = 32'h0003_0000;
    bus.valid_strobe_in = 1'b1;
    cyc();
    bus.valid_strobe_in = 1'b0;
  endtask

  logic [31:0] sat_vals [4];
  logic [15:0] sat_exp  [4];

  initial begin
    total = 0;
    bad   = 0;
    edge_n = 0;
    m_prev = 0;
    model_flush();
    rst_i               = 1'b1;
    clear_i             = 1'b0;
    bus.valid_strobe_in = 1'b0;
    bus.y_in            = '0;
    bus.ready_in        = 1'b0;

    // Reset state
    #1;
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_sample", 64'(bus.sample_out), 64'd0);
    check("rst_level", 64'(fill_level_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_sat", 64'(sat_count_o), 64'd0);
    check("rst_drop", 64'(drop_count_o), 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(2);

    // Rounding and 3-cycle latency
    bus.ready_in        = 1'b1;
    bus.y_in            = 32'h0000_4000;
    bus.valid_strobe_in = 1'b1;
    cyc();
    bus.valid_strobe_in = 1'b0;
    check("lat_c1_valid", 64'(bus.valid_out), 64'd0);
    cyc();
    check("lat_c2_valid", 64'(bus.valid_out), 64'd0);
    cyc();
    check("lat_c3_valid", 64'(bus.valid_out), 64'd1);
    check("round_sample", 64'(bus.sample_out), 64'h0001);
    check("round_sat", 64'(sat_count_o), 64'd0);
    idle(2);

    // Saturation
    sat_vals = '{32'h4000_0000, 32'hBFFF_0000, 32'hC000_0000, 32'h7FFF_FFFF};
    sat_exp  = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
    bus.ready_in = 1'b0;
    foreach (sat_vals[i]) send(sat_vals[i]);
    idle(3);
    check("sat_level", 64'(fill_level_o), 64'd4);
    bus.ready_in = 1'b1;
    foreach (sat_exp[i]) begin
      check("sat_sample", 64'(bus.sample_out), 64'(sat_exp[i]));
      cyc();
    end
    check("sat_count_final", 64'(sat_count_o), 64'd3);

    // Held strobe yields one event
    pulse_clear();
    bus.ready_in        = 1'b0;
    bus.y_in            = 32'h0001_0000;
    bus.valid_strobe_in = 1'b1;
    idle(10);
    bus.valid_strobe_in = 1'b0;
    idle(4);
    check("held_level", 64'(fill_level_o), 64'd1);
    check("held_sample", 64'(bus.sample_out), 64'h0002);

    // Overflow: 17 results into a 16-deep FIFO
    pulse_clear();
    bus.ready_in = 1'b0;
    for (int k = 1; k <= 17; k++) send(32'(k) << 15);
    idle(4);
    check("ovf_level", 64'(fill_level_o), 64'd16);
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_drop", 64'(drop_count_o), 64'd1);
    bus.ready_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("ovf_drain", 64'(bus.sample_out), 64'(k));
      cyc();
    end
    check("ovf_drained", 64'(bus.valid_out), 64'd0);

    // Simultaneous push and pop on a full FIFO
    pulse_clear();
    bus.ready_in = 1'b0;
    for (int k = 101; k <= 116; k++) send(32'(k) << 15);
    idle(3);
    check("sim_full", 64'(fill_level_o), 64'd16);
    bus.y_in            = 32'(200) << 15;
    bus.valid_strobe_in = 1'b1;
    cyc();
    bus.valid_strobe_in = 1'b0;
    cyc();
    bus.ready_in = 1'b1;
    cyc();
    bus.ready_in = 1'b0;
    check("sim_level", 64'(fill_level_o), 64'd16);
    check("sim_drop", 64'(drop_count_o), 64'd0);
    check("sim_ovf", 64'(overflow_o), 64'd0);
    bus.ready_in = 1'b1;
    for (int k = 102; k <= 116; k++) begin
      check("sim_drain", 64'(bus.sample_out), 64'(k));
      cyc();
    end
    check("sim_tail", 64'(bus.sample_out), 64'd200);
    cyc();

    // Reset mid-flight
    pulse_clear();
    queue_five_and_launch();
    rst_i = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.valid_out), 64'd0);
    check("midrst_level", 64'(fill_level_o), 64'd0);
    check("midrst_sat", 64'(sat_count_o), 64'd0);
    check("midrst_drop", 64'(drop_count_o), 64'd0);
    model_flush();
    m_prev = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(6);
    check("midrst_no_ghost", 64'(bus.valid_out), 64'd0);

    // Clear mid-flight
    queue_five_and_launch();
    check("preclr_sat", 64'(sat_count_o), 64'd1);
    pulse_clear();
    check("midclr_valid", 64'(bus.valid_out), 64'd0);
    check("midclr_level", 64'(fill_level_o), 64'd0);
    check("midclr_sat", 64'(sat_count_o), 64'd0);
    idle(6);
    check("midclr_no_ghost", 64'(bus.valid_out), 64'd0);

    // Randomized traffic
    begin
      int ready_bias;
      logic [31:0] y;
      ready_bias = 2;
      for (int n = 0; n < 1500; n++) begin
        if (n % 100 == 0) ready_bias = int'($urandom_range(0, 4));
        if (bus.valid_strobe_in) begin
          if ($urandom_range(0, 1) == 0) bus.valid_strobe_in = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          y = $urandom();
          if ($urandom_range(0, 1) == 0) y = {{10{y[21]}}, y[21:0]};
          bus.y_in            = y;
          bus.valid_strobe_in = 1'b1;
        end
        bus.ready_in = ($urandom_range(0, 4) < 32'(ready_bias));
        clear_i      = ($urandom_range(0, 199) == 0);
        cyc();
      end
      clear_i             = 1'b0;
      bus.valid_strobe_in = 1'b0;
      bus.ready_in        = 1'b1;
      idle(24);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/student_fir_result_sink.md
Name: student_fir_result_sink

Overview:
Receiving end of the FIR output interface. It captures each y_out word on the filter's valid strobe, then rounds, scales and saturates it back to sample width. Results are buffered in a small FIFO and drained by a downstream consumer (audio DAC path or a TL-UL reader) over a valid/ready handshake. It also tracks saturation events and dropped results.

Parameters:
DATA_SIZE_FIR_OUT, 32, width of the incoming accumulator word (two's complement)
DATA_SIZE, 16, width of the output sample (two's complement)
FRAC_SHIFT, 15, arithmetic right shift applied (coefficient fraction bits); legal range 1..DATA_SIZE_FIR_OUT-DATA_SIZE
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
CNT_WIDTH, 16, width of the saturation and drop counters

Ports:
clk_i  in  1  clock; the single clock domain
rst_i  in  1  asynchronous, active-high reset
valid_strobe_in  in  1  FIR result strobe; level input, rising edge is the event
y_in  in  DATA_SIZE_FIR_OUT  FIR accumulator; stable while valid_strobe_in is high
clear_i  in  1  synchronous flush of FIFO, pipeline, flags and counters
sample_out  out  DATA_SIZE  FIFO head sample
valid_out  out  1  FIFO non-empty; sample_out valid
ready_in  in  1  consumer accepts the head when valid_out && ready_in
fill_level_o  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2
overflow_o  out  1  sticky; set when a result was dropped on a full FIFO
sat_count_o  out  CNT_WIDTH  number of saturated results; holds at max
drop_count_o  out  CNT_WIDTH  number of dropped results; holds at max

Behaviour:
- Reset (async, rst_i=1):
  - Outputs: sample_out=0, valid_out=0, fill_level_o=0, overflow_o=0, both counters 0.
  - Internal state: pointers=0, pipeline valids=0, edge-detect previous=0.
  - Reset mid-operation discards FIFO contents and in-flight results.
- Event detection: event = valid_strobe_in && !prev, where prev is the registered strobe. A strobe held high produces exactly one event.
- Pipeline:
  - S1: on an event in cycle N, y_in is registered at the end of N.
  - S2: round/saturate, registered at the end of N+1.
  - S3: FIFO write at the end of N+2.
  - Into an empty FIFO, valid_out rises in cycle N+3. Latency is 3 cycles.
- Arithmetic:
  - Work in DATA_SIZE_FIR_OUT+1 bits, sign-extended, so the rounding add cannot wrap.
  - r = (y + 2**(FRAC_SHIFT-1)) >>> FRAC_SHIFT, i.e. round half toward +inf.
  - If r > 2**(DATA_SIZE-1)-1, output 0x7FFF. If r < -2**(DATA_SIZE-1), output 0x8000. Either case increments sat_count_o at the S2 register.
  - Otherwise output r[DATA_SIZE-1:0].
- FIFO:
  - Show-ahead: sample_out reflects the head entry combinationally from the registered memory/pointers.
  - Pop when valid_out && ready_in.
  - Push when S3 is valid and (not full, or pop in the same cycle).
  - Push and pop in the same cycle: fill_level_o unchanged.
  - Full with push and no pop: the result is dropped, overflow_o is set, drop_count_o increments. Existing FIFO contents are unchanged.
  - Empty with ready_in=1: no effect. sample_out is don't-care while valid_out=0.
  - Pointers wrap modulo 2**DEPTH_LOG2. The extra bit distinguishes full from empty.
- clear_i:
  - Effective at the clock edge; has the same effect as reset but is synchronous.
  - Overrides a simultaneous push, pop or event.
  - An event in the clear cycle is ignored. prev is still updated, so a held strobe does not re-trigger.
- Counters saturate at 2**CNT_WIDTH-1; they never wrap.
- Back-to-back events, as close as every 2 cycles, are all processed. The pipeline has no stall; backpressure is absorbed only by the FIFO.

Decomposition:
- student_fir_pkg holds:
  - a round_sat function (parameterised by widths, returns value and sat flag);
  - localparams for default widths and FRAC_SHIFT.
- Sub-module student_sync_fifo:
  - parameters WIDTH and DEPTH_LOG2; async active-high reset; synchronous clear;
  - push/pop/full/empty/level/rdata ports; drop logic stays in the parent.

Test Plan:
- Rounding: y_in=0x0000_4000 (FRAC_SHIFT=15), ready_in=1 -> sample_out=0x0001, valid_out high exactly 3 cycles after the strobe edge, sat_count_o=0.
- Saturation: y_in=0x4000_0000 -> 0x7FFF. y_in=0xBFFF_0000 -> 0x8000. y_in=0xC000_0000 -> 0x8000 with no saturation. y_in=0x7FFF_FFFF -> 0x7FFF. Final sat_count_o=3.
- Held strobe: valid_strobe_in high for 10 cycles with y_in=0x0001_0000 -> exactly one entry 0x0002, fill_level_o=1.
- Overflow: ready_in=0, 17 events with y_in=k<<15 (k=1..17) -> fill_level_o=16, overflow_o=1, drop_count_o=1. Then ready_in=1 drains 0x0001..0x0010 in order.
- Simultaneous push/pop: FIFO full, ready_in=1, event arriving -> fill_level_o stays 16, no drop, new value lands at the tail.
- Reset/clear mid-flight: assert rst_i (and separately clear_i) one cycle after an event with 5 entries queued -> next cycle valid_out=0, fill_level_o=0, counters 0, in-flight result never appears.
